// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } mdu_state_e;

    function automatic logic is_div(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(input mdu_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(input mdu_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module mdu_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mdu_multicycle.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle, fixed WIDTH+1 latency.
// Optional: define MDU_EARLY_OUT_EN to send divide-by-zero / signed overflow straight to FIN.
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e state, next_state;

    mdu_op_e            op;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     rem;
    logic               neg_a;
    logic               neg_b;
    logic               div_zero;
    logic               overflow;

    mdu_op_e          in_op;
    logic             in_neg_a;
    logic             in_neg_b;
    logic             in_div_zero;
    logic             in_overflow;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;

    logic [WIDTH:0]   mul_sum;
    logic             div_ge;
    logic [WIDTH-1:0] div_rest;

    logic               is_rem_op;
    logic [WIDTH-1:0]   div_val;
    logic               div_neg;
    logic [WIDTH-1:0]   div_fixed;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   fin_result;

    always_comb begin
        in_op       = mdu_op_e'(Funct3);
        in_neg_a    = a_signed(in_op) & SrcA[WIDTH-1];
        in_neg_b    = b_signed(in_op) & SrcB[WIDTH-1];
        in_div_zero = is_div(in_op) && (SrcB == '0);
        in_overflow = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                      (SrcA == MOST_NEG) && (SrcB == '1);
    end

    mdu_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value  (SrcA),
        .negate (in_neg_a),
        .result (in_mag_a)
    );

    mdu_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value  (SrcB),
        .negate (in_neg_b),
        .result (in_mag_b)
    );

    // rem holds the already-shifted partial remainder, so its top bit feeds the compare
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
        div_ge   = (rem >= {1'b0, mag_b});
        div_rest = div_ge ? WIDTH'(rem - {1'b0, mag_b}) : rem[WIDTH-1:0];
    end

    always_comb begin
        is_rem_op = (op == OP_REM) || (op == OP_REMU);
        div_val   = is_rem_op ? (div_zero ? mag_a : rem[WIDTH:1]) : quo;
        div_neg   = is_rem_op ? neg_a : (neg_a ^ neg_b);
    end

    mdu_abs #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value  (prod),
        .negate (neg_a ^ neg_b),
        .result (prod_fixed)
    );

    mdu_abs #(.WIDTH(WIDTH)) u_fix_div (
        .value  (div_val),
        .negate (div_neg),
        .result (div_fixed)
    );

    // Special-case flags captured at Start override the iterative result
    always_comb begin
        fin_result = '0;
        case (op)
            OP_MUL:                       fin_result = prod_fixed[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod_fixed[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: begin
                if (div_zero)      fin_result = '1;
                else if (overflow) fin_result = MOST_NEG;
                else               fin_result = div_fixed;
            end
            OP_REM, OP_REMU:              fin_result = overflow ? '0 : div_fixed;
            default:                      fin_result = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Start) begin
`ifdef MDU_EARLY_OUT_EN
                    next_state = (in_div_zero || in_overflow) ? FIN : CALC;
`else
                    next_state = CALC;
`endif
                end
            end
            CALC:    if (count == '0) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state != IDLE);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            op       <= OP_MUL;
            count    <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            prod     <= '0;
            quo      <= '0;
            rem      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
            Result   <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (Start) begin
                        op       <= in_op;
                        count    <= CW'(WIDTH-1);
                        mag_a    <= in_mag_a;
                        mag_b    <= in_mag_b;
                        neg_a    <= in_neg_a;
                        neg_b    <= in_neg_b;
                        div_zero <= in_div_zero;
                        overflow <= in_overflow;
                        prod     <= {{WIDTH{1'b0}}, in_mag_b};
                        rem      <= {{WIDTH{1'b0}}, in_mag_a[WIDTH-1]};
                        quo      <= {in_mag_a[WIDTH-2:0], 1'b0};
                    end
                end
                CALC: begin
                    count <= count - CW'(1);
                    if (is_div(op)) begin
                        rem <= {div_rest, quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], div_ge};
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                end
                FIN:     Result <= fin_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed cases plus randomized ops vs a 64-bit arithmetic model.
module tb_mdu_multicycle;

    localparam int W = 32;

    logic         CLK;
    logic         Reset;
    logic         Start;
    logic [2:0]   Funct3;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;

    int checks = 0;
    int passes = 0;

    mdu_multicycle #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .Reset  (Reset),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int expectedLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (f[2] && (b == 0)) ||
                  (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
`ifdef MDU_EARLY_OUT_EN
        return special ? 1 : W + 1;
`else
        return (special !== 1'bx) ? W + 1 : W + 1;
`endif
    endfunction

    // Called #1 after the accepting edge; counts edges and Busy cycles until Done
    task automatic waitDone(input string tag, input int expLat, input logic [31:0] expRes);
        int edges = 0;
        int busyCycles = 0;
        while ((Done !== 1'b1) && (edges < 200)) begin
            if (Busy === 1'b1) busyCycles++;
            @(posedge CLK); #1;
            edges++;
        end
        checkOutput({tag, " done"}, 64'(Done), 64'd1);
        checkOutput({tag, " latency"}, 64'(edges), 64'(expLat));
        checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'(expLat));
        checkOutput({tag, " result"}, 64'(Result), 64'(expRes));
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] expRes;
        expRes = refModel(f, a, b);
        @(negedge CLK);
        Funct3 = f;
        SrcA   = a;
        SrcB   = b;
        Start  = 1'b1;
        @(posedge CLK); #1;
        Start  = 1'b0;
        Funct3 = 3'($urandom_range(0, 7));
        SrcA   = $urandom;
        SrcB   = $urandom;
        waitDone(tag, expectedLatency(f, a, b), expRes);
        @(posedge CLK); #1;
        checkOutput({tag, " done pulse width"}, 64'(Done), 64'd0);
        checkOutput({tag, " result hold"}, 64'(Result), 64'(expRes));
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b, expFirst, expSecond;
        int          sel, doneSeen;

        Reset  = 1'b1;
        Start  = 1'b0;
        Funct3 = 3'd0;
        SrcA   = '0;
        SrcB   = '0;
        #1;
        checkOutput("reset busy", 64'(Busy), 64'd0);
        checkOutput("reset done", 64'(Done), 64'd0);
        checkOutput("reset result", 64'(Result), 64'd0);
        repeat (2) @(negedge CLK);
        Reset = 1'b0;

        applyStimulus("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        applyStimulus("mulhu ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus("mulh ones", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus("mulhsu ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        applyStimulus("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        applyStimulus("divu 100/7", 3'd5, 32'd100, 32'd7);
        applyStimulus("remu 100/7", 3'd7, 32'd100, 32'd7);
        applyStimulus("divu 5/0", 3'd5, 32'd5, 32'd0);
        applyStimulus("remu 5/0", 3'd7, 32'd5, 32'd0);
        applyStimulus("div -7/0", 3'd4, 32'hFFFF_FFF9, 32'd0);
        applyStimulus("rem -7/0", 3'd6, 32'hFFFF_FFF9, 32'd0);
        applyStimulus("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Start held high through CALC with new operands, then accepted in the Done cycle
        expFirst  = refModel(3'd0, 32'd1234, 32'd5678);
        expSecond = refModel(3'd5, 32'd1000, 32'd9);
        @(negedge CLK);
        Funct3 = 3'd0;
        SrcA   = 32'd1234;
        SrcB   = 32'd5678;
        Start  = 1'b1;
        @(posedge CLK); #1;
        Funct3 = 3'd5;
        SrcA   = 32'd1000;
        SrcB   = 32'd9;
        waitDone("b2b first", W + 1, expFirst);
        @(posedge CLK); #1;
        Start  = 1'b0;
        SrcA   = $urandom;
        SrcB   = $urandom;
        waitDone("b2b second", W + 1, expSecond);

        // Reset ten cycles into a divide must abort it silently
        applyStimulus("divu before reset", 3'd5, 32'd100, 32'd7);
        @(negedge CLK);
        Funct3 = 3'd4;
        SrcA   = 32'd987654;
        SrcB   = 32'd321;
        Start  = 1'b1;
        @(posedge CLK); #1;
        Start  = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("abort busy", 64'(Busy), 64'd0);
        checkOutput("abort done", 64'(Done), 64'd0);
        checkOutput("abort result", 64'(Result), 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (Done === 1'b1) doneSeen++;
        end
        checkOutput("abort no done", 64'(doneSeen), 64'd0);
        applyStimulus("mul 3*4 after reset", 3'd0, 32'd3, 32'd4);

        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            applyStimulus($sformatf("rand%0d op%0d", i, f), f, a, b);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
